// File: rtl/aud_pkg.sv
// Shared definitions for the codec-configuration I2C responder.
package aud_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ACK_A,
        S_BYTE_H,
        S_ACK_H,
        S_BYTE_L,
        S_ACK_L,
        S_IGNORE
    } i2c_resp_state_e;

    localparam logic [6:0]  WM_DEV_ADDR  = 7'h1A;
    localparam logic [6:0]  WM_REG_RESET = 7'h0F;
    localparam int unsigned WM_NUM_REGS  = 16;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizer with edge flops; decodes SCL edges and START/STOP
// conditions from the synchronized bus levels.
module i2c_bus_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    localparam int unsigned STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] scl_sync;
    logic [STAGES-1:0] sda_sync;
    logic              scl;
    logic              scl_d;
    logic              sda_d;

    // Flops reset to the idle-bus level so release of reset is not an edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[STAGES-2:0], i_scl};
            sda_sync <= {sda_sync[STAGES-2:0], i_sda};
            scl_d    <= scl_sync[STAGES-1];
            sda_d    <= sda_sync[STAGES-1];
        end
    end

    assign scl      = scl_sync[STAGES-1];
    assign sda      = sda_sync[STAGES-1];
    assign scl_rise = scl & ~scl_d;
    assign scl_fall = ~scl & scl_d;
    // SDA edges only count as START/STOP while SCL has been high for a cycle.
    assign start    = scl & scl_d & sda_d & ~sda;
    assign stop     = scl & scl_d & ~sda_d & sda;

endmodule

// File: rtl/i2c_codec_responder.sv
// WM8731-style I2C write responder: decodes {index[6:0], value[8:0]} words.
// Optional shadow register file enabled by defining I2C_REGFILE_EN.
module i2c_codec_responder
    import aud_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR    = WM_DEV_ADDR,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned NUM_REGS    = WM_NUM_REGS
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_oen,
    output logic       o_wr_valid,
    output logic [6:0] o_wr_addr,
    output logic [8:0] o_wr_data,
    output logic       o_busy,
    input  logic [3:0] i_rd_addr,
    output logic [8:0] o_rd_data
);

    logic            sda;
    logic            scl_rise;
    logic            scl_fall;
    logic            start;
    logic            stop;

    i2c_resp_state_e state;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic [7:0]      hi_byte;
    logic [7:0]      next_byte;

    i2c_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_scl   (i_scl),
        .i_sda   (i_sda),
        .sda     (sda),
        .scl_rise(scl_rise),
        .scl_fall(scl_fall),
        .start   (start),
        .stop    (stop)
    );

    assign next_byte = {shreg[6:0], sda};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            hi_byte    <= '0;
            o_sda_oen  <= 1'b0;
            o_wr_valid <= 1'b0;
            o_wr_addr  <= '0;
            o_wr_data  <= '0;
            o_busy     <= 1'b0;
        end else begin
            o_wr_valid <= 1'b0;
            if (stop) begin
                state     <= S_IDLE;
                bit_cnt   <= '0;
                o_sda_oen <= 1'b0;
                o_busy    <= 1'b0;
            end else if (start) begin
                state     <= S_ADDR;
                bit_cnt   <= '0;
                o_sda_oen <= 1'b0;
                o_busy    <= 1'b1;
            end else begin
                case (state)
                    S_ADDR, S_BYTE_H, S_BYTE_L: begin
                        if (scl_rise) begin
                            shreg   <= next_byte;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                case (state)
                                    S_ADDR: begin
                                        state <= (next_byte == {DEV_ADDR, 1'b0}) ? S_ACK_A : S_IGNORE;
                                    end
                                    S_BYTE_H: begin
                                        hi_byte <= next_byte;
                                        state   <= S_ACK_H;
                                    end
                                    default: begin
                                        o_wr_addr  <= hi_byte[7:1];
                                        o_wr_data  <= {hi_byte[0], next_byte};
                                        o_wr_valid <= 1'b1;
                                        state      <= S_ACK_L;
                                    end
                                endcase
                            end
                        end
                    end
                    // oen itself marks the two halves of the ACK slot.
                    S_ACK_A, S_ACK_H, S_ACK_L: begin
                        if (scl_fall) begin
                            if (!o_sda_oen) begin
                                o_sda_oen <= 1'b1;
                            end else begin
                                o_sda_oen <= 1'b0;
                                state     <= (state == S_ACK_H) ? S_BYTE_L : S_BYTE_H;
                            end
                        end
                    end
                    S_IDLE, S_IGNORE: begin
                        o_sda_oen <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef I2C_REGFILE_EN
    localparam int unsigned AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [8:0] shadow [NUM_REGS];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
        end else if (o_wr_valid) begin
            if (o_wr_addr == WM_REG_RESET) begin
                for (int unsigned i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
            end else if (32'(o_wr_addr) < NUM_REGS) begin
                shadow[o_wr_addr[AW-1:0]] <= o_wr_data;
            end
        end
    end

    always_comb begin
        o_rd_data = '0;
        if (32'(i_rd_addr) < NUM_REGS) o_rd_data = shadow[i_rd_addr[AW-1:0]];
    end
`else
    logic unused_rd;
    assign unused_rd = ^{i_rd_addr, NUM_REGS == 0};
    assign o_rd_data = '0;
`endif

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Randomized bench with an open-drain bus master and a frame-level model of
// the expected ACKs, write strobes and shadow registers.
module tb_i2c_codec_responder;

    typedef logic [7:0] bq_t[$];

    localparam int QTR = 25;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_bus;
    logic       sda_oen;
    logic       wr_valid;
    logic [6:0] wr_addr;
    logic [8:0] wr_data;
    logic       busy;
    logic [3:0] rd_addr = '0;
    logic [8:0] rd_data;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] obs_q[$];
    logic [15:0] exp_q[$];
    logic [8:0]  shadow_m[16];
    bit          oen_seen;

    always #10 clk = ~clk;

    assign sda_bus = (!m_sda || sda_oen) ? 1'b0 : 1'b1;

    i2c_codec_responder dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_scl     (m_scl),
        .i_sda     (sda_bus),
        .o_sda_oen (sda_oen),
        .o_wr_valid(wr_valid),
        .o_wr_addr (wr_addr),
        .o_wr_data (wr_data),
        .o_busy    (busy),
        .i_rd_addr (rd_addr),
        .o_rd_data (rd_data)
    );

    always @(negedge clk) begin
        if (wr_valid) obs_q.push_back({wr_addr, wr_data});
        if (sda_oen) oen_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic qwait();
        repeat (QTR) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; qwait();
        m_scl = 1'b1; qwait();
        m_sda = 1'b0; qwait();
        m_scl = 1'b0; qwait();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; qwait();
        m_scl = 1'b1; qwait();
        m_sda = 1'b1; qwait();
        qwait(); qwait();
    endtask

    task automatic send_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            m_sda = b[i]; qwait();
            m_scl = 1'b1; qwait(); qwait();
            m_scl = 1'b0; qwait();
        end
        m_sda = 1'b1;
    endtask

    task automatic write_byte(input logic [7:0] b, output bit ack);
        send_bits(b);
        qwait();
        m_scl = 1'b1; qwait();
        ack = !sda_bus; qwait();
        m_scl = 1'b0; qwait();
    endtask

    function automatic void model_word(input logic [6:0] a, input logic [8:0] d);
        exp_q.push_back({a, d});
        if (a == 7'h0F) begin
            for (int i = 0; i < 16; i++) shadow_m[i] = '0;
        end else if (a < 7'd16) begin
            shadow_m[a[3:0]] = d;
        end
    endfunction

    // One START-delimited segment: the frame is acknowledged only for a
    // write to 0x1A; byte pairs after the address form words, an odd tail is lost.
    task automatic run_segment(input bq_t b, input string tag);
        bit matched;
        bit ack;
        matched = (b[0] == 8'h34);
        i2c_start();
        check({tag, " busy@start"}, busy, 1);
        for (int i = 0; i < b.size(); i++) begin
            write_byte(b[i], ack);
            check($sformatf("%s ack%0d", tag, i), ack, matched);
        end
        if (matched)
            for (int i = 1; i + 1 < b.size(); i += 2)
                model_word(b[i][7:1], {b[i][0], b[i+1]});
    endtask

    task automatic end_frame(input string tag);
        i2c_stop();
        check({tag, " busy@stop"}, busy, 0);
        check({tag, " oen@stop"}, sda_oen, 0);
        check({tag, " nstrobe"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check($sformatf("%s strobe%0d", tag, i), obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_read(input logic [3:0] a, input string tag);
        rd_addr = a;
        @(negedge clk);
`ifdef I2C_REGFILE_EN
        check($sformatf("%s rd%0d", tag, a), rd_data, shadow_m[a]);
`else
        check($sformatf("%s rd%0d", tag, a), rd_data, 0);
`endif
    endtask

    initial begin
        bq_t f;
        bit  got_oen;
        logic [7:0] t;
        int  n;

        for (int i = 0; i < 16; i++) shadow_m[i] = '0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("reset oen", sda_oen, 0);
        check("reset valid", wr_valid, 0);
        check("reset busy", busy, 0);
        check("reset addr", wr_addr, 0);
        check("reset data", wr_data, 0);
        check("reset rd", rd_data, 0);

        f = '{8'h34, 8'h1E, 8'h00};
        run_segment(f, "s1"); end_frame("s1");

        oen_seen = 1'b0;
        f = '{8'h36, 8'hA5, 8'h5A};
        run_segment(f, "s2"); end_frame("s2");
        check("s2 oen never", oen_seen, 0);

        f = '{8'h34, 8'h08, 8'h15, 8'h0A, 8'h77};
        run_segment(f, "s3"); end_frame("s3");
        check_read(4'd4, "s3");
        check_read(4'd5, "s3");

        f = '{8'h34, 8'h08};
        run_segment(f, "s4a"); end_frame("s4a");
        f = '{8'h34, 8'h0E, 8'h4F};
        run_segment(f, "s4b"); end_frame("s4b");

        f = '{8'h34, 8'h08};
        run_segment(f, "s5a");
        f = '{8'h34, 8'h12, 8'h01};
        run_segment(f, "s5b"); end_frame("s5");

        for (int r = 0; r < 8; r++) begin
            f.delete();
            t = ($urandom_range(0, 3) != 0) ? 8'h34 : 8'($urandom);
            f.push_back(t);
            n = $urandom_range(0, 5);
            for (int i = 0; i < n; i++) begin
                t = (i % 2 == 0) ? 8'($urandom_range(0, 31)) : 8'($urandom);
                f.push_back(t);
            end
            run_segment(f, $sformatf("r%0d", r));
            end_frame($sformatf("r%0d", r));
        end
        for (int a = 0; a < 16; a++) check_read(4'(a), "rand");

        f = '{8'h34, 8'h1E, 8'h00};
        run_segment(f, "clr"); end_frame("clr");
        for (int a = 0; a < 16; a += 5) check_read(4'(a), "clr");

        f = '{8'h34, 8'h06, 8'h1C};
        run_segment(f, "pre"); end_frame("pre");
        i2c_start();
        send_bits(8'h34);
        got_oen = 1'b0;
        for (int i = 0; i < 200 && !got_oen; i++) begin
            @(negedge clk);
            got_oen = sda_oen;
        end
        check("rst oen asserted", got_oen, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst oen released", sda_oen, 0);
        check("rst busy", busy, 0);
        check("rst addr", wr_addr, 0);
        for (int i = 0; i < 16; i++) shadow_m[i] = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_scl = 1'b1; qwait();
        m_scl = 1'b0; qwait();
        obs_q.delete();
        exp_q.delete();
        end_frame("rst");
        check_read(4'd3, "rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
